// File: rtl/master_bus_arbiter_pkg.sv
// Shared types for the two-master common-bus arbiter: FSM states, master ids
// and the timeout counter width.
package master_bus_arbiter_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } arb_state_e;

  typedef enum logic {
    MST_A = 1'b0,
    MST_B = 1'b1
  } master_id_e;

  function automatic master_id_e other_master(input master_id_e id);
    return (id == MST_A) ? MST_B : MST_A;
  endfunction

endpackage

// File: rtl/master_bus_arbiter_if.sv
// Common-bus handshake between the arbiter, its two requesting masters and the
// shared slave.
interface master_bus_arbiter_if;

  logic reqA;
  logic reqB;
  logic slaveReady;
  logic useA;
  logic slaveValid;
  logic doneA;
  logic doneB;
  logic busError;

  // Arbiter side of the bus.
  modport master (
    input  reqA, reqB, slaveReady,
    output useA, slaveValid, doneA, doneB, busError
  );

  // Requesters/slave side of the bus.
  modport slave (
    output reqA, reqB, slaveReady,
    input  useA, slaveValid, doneA, doneB, busError
  );

endinterface

// File: rtl/master_bus_arbiter.sv
// Round-robin arbiter granting one of two masters onto a common bus, with a
// per-access timeout that aborts a stalled slave and flags busError.
module master_bus_arbiter
  import master_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  master_bus_arbiter_if.master bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e       state_q, state_d;
  logic             useA_q, useA_d;
  master_id_e       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire;
  logic             finish;
  logic             owned;

  assign owned  = (state_q != ST_IDLE);
  assign expire = (cnt_q == LAST_CNT);
  // Slave completion wins over the timeout when both land in the same cycle.
  assign finish = owned && (bus.slaveReady || expire);

  always_comb begin
    state_d = state_q;
    useA_d  = useA_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.reqA && (!bus.reqB || other_master(last_q) == MST_A)) begin
          state_d = ST_OWN_A;
          useA_d  = 1'b1;
        end else if (bus.reqB) begin
          state_d = ST_OWN_B;
          useA_d  = 1'b0;
        end
      end
      ST_OWN_A: begin
        if (finish) begin
          last_d = MST_A;
          cnt_d  = '0;
          if (bus.reqB) begin
            state_d = ST_OWN_B;
            useA_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_OWN_B: begin
        if (finish) begin
          last_d = MST_B;
          cnt_d  = '0;
          // Handover only to the other master; a persistent B goes through IDLE.
          if (bus.reqA) begin
            state_d = ST_OWN_A;
            useA_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      useA_q  <= 1'b1;
      last_q  <= MST_B;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      useA_q  <= useA_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.useA       = useA_q;
  assign bus.slaveValid = owned;
  assign bus.doneA      = (state_q == ST_OWN_A) && finish;
  assign bus.doneB      = (state_q == ST_OWN_B) && finish;
  assign bus.busError   = finish && !bus.slaveReady;

endmodule

// File: tb/tb_master_bus_arbiter.sv
// Directed-vector bench for master_bus_arbiter (TIMEOUT_CYCLES=4); each row
// drives one cycle of inputs and checks {slaveValid,useA,doneA,doneB,busError}.
module tb_master_bus_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  master_bus_arbiter_if bus_if ();

  master_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got[4:0], exp[4:0]);
    end
  endtask

  function automatic logic [4:0] obs();
    return {bus_if.slaveValid, bus_if.useA, bus_if.doneA, bus_if.doneB, bus_if.busError};
  endfunction

  // One cycle: drive just after the rising edge, check in mid-cycle.
  task automatic row(input string tag, input logic rn, input logic a, input logic b,
                     input logic r, input logic [4:0] exp);
    @(posedge clk);
    #1;
    rst_n               = rn;
    bus_if.reqA         = a;
    bus_if.reqB         = b;
    bus_if.slaveReady   = r;
    @(negedge clk);
    check_eq(tag, 32'(obs()), 32'(exp));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n             = 1'b0;
    bus_if.reqA       = 1'b1;
    bus_if.reqB       = 1'b1;
    bus_if.slaveReady = 1'b1;

    // {valid,useA,doneA,doneB,err}
    row("rst_hold0",   0, 1, 1, 1, 5'b01000);
    row("rst_hold1",   0, 1, 1, 1, 5'b01000);
    row("rst_release", 1, 1, 1, 0, 5'b01000);
    row("cont_A1",     1, 1, 1, 1, 5'b11100);
    row("cont_B1",     1, 1, 1, 1, 5'b10010);
    row("cont_A2",     1, 1, 1, 1, 5'b11100);
    row("cont_B2_end", 1, 0, 0, 1, 5'b10010);
    row("idle_rdy",    1, 0, 0, 1, 5'b00000);

    row("sB_idle",     1, 0, 1, 0, 5'b00000);
    row("sB_w1",       1, 0, 1, 0, 5'b10000);
    row("sB_w2",       1, 0, 1, 0, 5'b10000);
    row("sB_w3",       1, 0, 1, 0, 5'b10000);
    row("sB_done",     1, 0, 0, 1, 5'b10010);
    row("sB_after",    1, 0, 0, 0, 5'b00000);

    row("toA_idle",    1, 1, 0, 0, 5'b00000);
    row("toA_w1",      1, 0, 0, 0, 5'b11000);
    row("toA_w2",      1, 0, 0, 0, 5'b11000);
    row("toA_w3",      1, 0, 0, 0, 5'b11000);
    row("toA_abort",   1, 0, 0, 0, 5'b11101);
    row("toA_after",   1, 0, 0, 0, 5'b01000);

    row("rdyA_idle",   1, 1, 0, 0, 5'b01000);
    row("rdyA_w1",     1, 1, 0, 0, 5'b11000);
    row("rdyA_w2",     1, 1, 0, 0, 5'b11000);
    row("rdyA_w3",     1, 1, 0, 0, 5'b11000);
    row("rdyA_last",   1, 0, 0, 1, 5'b11100);
    row("rdyA_after",  1, 0, 0, 0, 5'b01000);

    row("persA_idle1", 1, 1, 0, 1, 5'b01000);
    row("persA_own1",  1, 1, 0, 1, 5'b11100);
    row("persA_idle2", 1, 1, 0, 1, 5'b01000);
    row("persA_own2",  1, 0, 0, 1, 5'b11100);
    row("persA_after", 1, 0, 0, 0, 5'b01000);

    row("rr_idle",     1, 1, 1, 0, 5'b01000);
    row("rrB_w1",      1, 1, 1, 0, 5'b10000);
    row("rrB_w2",      1, 1, 1, 0, 5'b10000);
    row("rrB_w3",      1, 1, 1, 0, 5'b10000);
    row("rrB_abort",   1, 1, 1, 0, 5'b10011);
    row("hoA_w1",      1, 1, 1, 0, 5'b11000);
    row("hoA_done",    1, 0, 1, 1, 5'b11100);
    row("mrB_w1",      1, 0, 1, 0, 5'b10000);

    // Asynchronous reset in the middle of the OWN_B wait.
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mr_async", 32'(obs()), 32'(5'b01000));
    row("mr_hold",     0, 0, 1, 1, 5'b01000);
    row("mr_release",  1, 1, 1, 1, 5'b01000);
    row("mr_firstA",   1, 0, 0, 1, 5'b11100);
    row("mr_after",    1, 0, 0, 0, 5'b01000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
